bcd_serial_add_sub_ctrl: RTL

//  Digit-serial controller for multi-digit packed-BCD add/subtract.
//  - Sits directly upstream of the combinational single-digit BCD add/sub stage
//    (9's-complement generator + BCD adder).
//  - Feeds that stage one digit pair per clock, LSD first, and chains its carry.
//  - Collects result digits, applies sign/recomplement correction, and reports

---
 rtl/bcd_serial_add_sub_ctrl_pkg.sv | 23 ++
 rtl/bcd_shift_reg.sv | 28 ++
 rtl/bcd_serial_add_sub_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_add_sub_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD add/subtract controller:
// state encoding, digit constants and the digit-counter width helper.
package bcd_serial_add_sub_ctrl_pkg;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ADD,
    ST_RECOMP,
    ST_DONE
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// NDIG-digit BCD register: parallel load, parallel clear, and a right shift
// that drops digit 0 and inserts the new digit at the MSD.
module bcd_shift_reg #(
  parameter int NDIG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clr,
  input  logic            shift,
  input  logic [4*NDIG-1:0] load_val,
  input  logic [3:0]      din,
  output logic [4*NDIG-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {din, q[4*NDIG-1:4]};
    end
  end

endmodule

// File: rtl/bcd_serial_add_sub_ctrl.sv
// Digit-serial sequencer for packed-BCD add/subtract around an external
// single-digit BCD add/sub stage, with recomplement of negative differences.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for start; operands latched on acceptance
// ST_CHECK  | one cycle: reject operands holding a nibble above 9
// ST_ADD    | NDIG cycles: feed A[i], B[i] to the stage, LSD first
// ST_RECOMP | NDIG cycles: 10's-complement the stored result (A<B on subtract)
// ST_DONE   | last busy cycle; done is registered out of this state
module bcd_serial_add_sub_ctrl
  import bcd_serial_add_sub_ctrl_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_sub,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              carry_out,
  output logic              negative,
  output logic              err,
  output logic [3:0]        dig_a,
  output logic [3:0]        dig_b,
  output logic              dig_m,
  output logic              dig_cin,
  input  logic [3:0]        dig_f,
  input  logic              dig_cout
);

  localparam int W  = DIG_W * NDIG;
  localparam int CW = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q, b_q, r_q;
  logic op_q, carry_q, done_q;
  logic carry_out_q, negative_q, err_q;
  logic accept, bad_digit, first, last;
  logic sh_ops, sh_res, clr_res, cnt_load;

  // done is registered out of ST_DONE, so the IDLE cycle that carries it is
  // still busy and must not accept a new request.
  assign accept = (state == ST_IDLE) && start && !done_q;
  assign first  = (cnt == CNT_TOP);
  assign last   = (cnt == '0);

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (a_q[DIG_W*i +: DIG_W] > BCD_MAX || b_q[DIG_W*i +: DIG_W] > BCD_MAX)
        bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    dig_a     = '0;
    dig_b     = '0;
    dig_m     = 1'b0;
    dig_cin   = 1'b0;
    sh_ops    = 1'b0;
    sh_res    = 1'b0;
    clr_res   = 1'b0;
    cnt_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          clr_res   = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_load = 1'b1;
        if (bad_digit) begin
          clr_res   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_ADD;
        end
      end
      ST_ADD: begin
        dig_a   = a_q[3:0];
        dig_b   = b_q[3:0];
        dig_m   = op_q;
        dig_cin = first ? op_q : carry_q;
        sh_ops  = 1'b1;
        sh_res  = 1'b1;
        if (last) begin
          cnt_load  = 1'b1;
          state_nxt = (op_q && !dig_cout) ? ST_RECOMP : ST_DONE;
        end
      end
      ST_RECOMP: begin
        // 0 + 9's complement of R + 1 on the LSD gives the 10's complement
        dig_b   = r_q[3:0];
        dig_m   = 1'b1;
        dig_cin = first ? 1'b1 : carry_q;
        sh_res  = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      negative_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_DONE);
      if (accept) begin
        op_q        <= op_sub;
        carry_q     <= 1'b0;
        carry_out_q <= 1'b0;
        negative_q  <= 1'b0;
        err_q       <= 1'b0;
      end
      if (state == ST_CHECK && bad_digit) err_q <= 1'b1;
      if (cnt_load) begin
        cnt <= CNT_TOP;
      end else if ((state == ST_ADD || state == ST_RECOMP) && !last) begin
        cnt <= cnt - 1'b1;
      end
      if (sh_res) carry_q <= dig_cout;
      if (state == ST_ADD && last) begin
        carry_out_q <= dig_cout;
        negative_q  <= op_q & ~dig_cout;
      end
    end
  end

  bcd_shift_reg #(.NDIG(NDIG)) u_a_reg (
    .clk(clk), .rst_n(rst_n), .load(accept), .clr(1'b0), .shift(sh_ops),
    .load_val(a_bcd), .din(4'd0), .q(a_q)
  );

  bcd_shift_reg #(.NDIG(NDIG)) u_b_reg (
    .clk(clk), .rst_n(rst_n), .load(accept), .clr(1'b0), .shift(sh_ops),
    .load_val(b_bcd), .din(4'd0), .q(b_q)
  );

  bcd_shift_reg #(.NDIG(NDIG)) u_r_reg (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .clr(clr_res), .shift(sh_res),
    .load_val('0), .din(dig_f), .q(r_q)
  );

  assign busy      = (state != ST_IDLE) || done_q;
  assign done      = done_q;
  assign result    = r_q;
  assign carry_out = carry_out_q;
  assign negative  = negative_q;
  assign err       = err_q;

endmodule
